sent_tx_frame_scheduler: RTL and testbench

//  Sequences the SENT transmit encoder: round-robin arbitrates fast-channel frame requests from NUM_REQ sources,

---
 rtl/sent_pkg.sv | 27 ++
 rtl/sent_crc4.sv | 20 ++
 rtl/sent_tx_frame_scheduler.sv | 169 ++++++++++++++++
 tb/tb_sent_tx_frame_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sent_pkg.sv
// Shared constants, SSM message layout and CRC4 lookup for the SENT transmit frame scheduler.
package sent_pkg;

  localparam int unsigned NIB_W            = 4;
  localparam int unsigned DATA_NIBBLES_DEF = 6;
  localparam int unsigned DW               = NIB_W * DATA_NIBBLES_DEF;
  localparam int unsigned SSM_LEN          = 16;
  localparam int unsigned SSM_IDX_W        = 4;

  localparam logic [3:0] CRC4_SEED = 4'b0101;
  // x^4+x^3+x^2+1 nibble table, entry i at bits [4*i +: 4]
  localparam logic [63:0] CRC4_LUT = 64'h582F_B6C1_493E_A7D0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  typedef struct packed {
    logic [3:0] id;
    logic [7:0] data;
    logic [3:0] crc;
  } ssm_msg_t;

  function automatic logic [3:0] crc4_lut(input logic [3:0] idx);
    return CRC4_LUT[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sent_crc4.sv
// SENT CRC4 over three nibbles, table-driven with the trailing zero-nibble augmentation.
module sent_crc4
  import sent_pkg::*;
(
  input  logic [3:0] nib0_i,
  input  logic [3:0] nib1_i,
  input  logic [3:0] nib2_i,
  output logic [3:0] crc_c_o
);

  logic [3:0] c1, c2, c3;

  always_comb begin
    c1      = crc4_lut(CRC4_SEED) ^ nib0_i;
    c2      = crc4_lut(c1) ^ nib1_i;
    c3      = crc4_lut(c2) ^ nib2_i;
    crc_c_o = crc4_lut(c3);
  end

endmodule

// File: rtl/sent_tx_frame_scheduler.sv
// Round-robin fast-channel frame scheduler for the SENT encoder, with Short Serial Message
// bits multiplexed into status nibble bits [3:2].
module sent_tx_frame_scheduler
  import sent_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_NIBBLES = DATA_NIBBLES_DEF
) (
  input  logic                             clk_tx,
  input  logic                             reset_tx,
  input  logic                             enable_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*4*DATA_NIBBLES-1:0] req_data_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [1:0]                       status_i,
  input  logic                             ssm_valid_i,
  input  logic [3:0]                       ssm_id_i,
  input  logic [7:0]                       ssm_data_i,
  output logic                             ssm_ready_o,
  output logic                             ssm_busy_o,
  output logic                             frame_valid_o,
  output logic [3:0]                       frame_status_o,
  output logic [4*DATA_NIBBLES-1:0]        frame_data_o,
  input  logic                             frame_ready_i,
  output logic [15:0]                      frame_cnt_o
);

  localparam int unsigned FDW   = 4 * DATA_NIBBLES;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [0:0]           state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [3:0]           fstat_q, fstat_d;
  logic [FDW-1:0]       fdata_q, fdata_d;
  logic                 fssm_q, fssm_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [SSM_LEN-1:0]   shift_q, shift_d;
  logic [SSM_IDX_W-1:0] idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 sready_q, sready_d;

  logic [PTR_W-1:0] win_c, cand_c;
  logic             found_c, grant_c, load_c, hs_c;
  logic             ssm_act_c, ssm_b3_c, ssm_b2_c;
  logic [3:0]       crc_c;
  ssm_msg_t         ld_msg_c;
  logic [FDW-1:0]   src_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
    assign src_data[g] = req_data_i[g*FDW +: FDW];
  end

  sent_crc4 u_crc4 (
    .nib0_i  (ssm_id_i),
    .nib1_i  (ssm_data_i[7:4]),
    .nib2_i  (ssm_data_i[3:0]),
    .crc_c_o (crc_c)
  );

  // Round-robin search starting one past the last winner
  always_comb begin
    found_c = 1'b0;
    win_c   = ptr_q;
    cand_c  = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = (cand_c == PTR_W'(NUM_REQ - 1)) ? '0 : cand_c + PTR_W'(1);
      if (!found_c && req_valid_i[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    fstat_d  = fstat_q;
    fdata_d  = fdata_q;
    fssm_d   = fssm_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    ld_msg_c = '{id: ssm_id_i, data: ssm_data_i, crc: crc_c};

    load_c  = ssm_valid_i & sready_q;
    hs_c    = (state_q == ST_OFFER) & frame_ready_i;
    grant_c = (state_q == ST_IDLE) & enable_i & found_c & ~reset_tx;
    req_ready_o = grant_c ? (NUM_REQ'(1) << win_c) : '0;

    // A load in the grant cycle is visible to the frame being granted
    if (load_c) begin
      ssm_act_c = 1'b1;
      ssm_b3_c  = 1'b1;
      ssm_b2_c  = ssm_id_i[3];
    end else begin
      ssm_act_c = busy_q;
      ssm_b3_c  = (idx_q == '0);
      ssm_b2_c  = shift_q[SSM_LEN-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          state_d = ST_OFFER;
          ptr_d   = win_c;
          fdata_d = src_data[win_c];
          fstat_d = {ssm_act_c & ssm_b3_c, ssm_act_c & ssm_b2_c, status_i};
          fssm_d  = ssm_act_c;
        end
      end
      ST_OFFER: begin
        if (hs_c) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only a frame that actually carried an SSM bit advances the message
    if (load_c) begin
      shift_d = ld_msg_c;
      idx_d   = '0;
      busy_d  = 1'b1;
    end else if (hs_c && fssm_q) begin
      shift_d = {shift_q[SSM_LEN-2:0], 1'b0};
      idx_d   = idx_q + SSM_IDX_W'(1);
      if (idx_q == SSM_IDX_W'(SSM_LEN - 1)) begin
        busy_d = 1'b0;
      end
    end
    sready_d = ~busy_d;
  end

  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      fstat_q  <= '0;
      fdata_q  <= '0;
      fssm_q   <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      sready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      fstat_q  <= fstat_d;
      fdata_q  <= fdata_d;
      fssm_q   <= fssm_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      sready_q <= sready_d;
    end
  end

  assign frame_valid_o  = (state_q == ST_OFFER);
  assign frame_status_o = fstat_q;
  assign frame_data_o   = fdata_q;
  assign frame_cnt_o    = cnt_q;
  assign ssm_busy_o     = busy_q;
  assign ssm_ready_o    = sready_q;

endmodule

// File: tb/tb_sent_tx_frame_scheduler.sv
// Self-checking bench for sent_tx_frame_scheduler: scoreboard of expected frames plus per-scenario checks.
module tb_sent_tx_frame_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DWT  = 24;

  logic             clk_tx = 1'b0;
  logic             reset_tx;
  logic             enable_i;
  logic [NREQ-1:0]  req_valid_i;
  logic [NREQ*DWT-1:0] req_data_i;
  logic [NREQ-1:0]  req_ready_o;
  logic [1:0]       status_i;
  logic             ssm_valid_i;
  logic [3:0]       ssm_id_i;
  logic [7:0]       ssm_data_i;
  logic             ssm_ready_o;
  logic             ssm_busy_o;
  logic             frame_valid_o;
  logic [3:0]       frame_status_o;
  logic [DWT-1:0]   frame_data_o;
  logic             frame_ready_i;
  logic [15:0]      frame_cnt_o;

  typedef struct packed {
    logic [3:0]     status;
    logic [DWT-1:0] data;
  } frame_t;

  frame_t sb[$];
  int n_cmp  = 0;
  int n_err  = 0;
  int hs_cnt = 0;
  int n_sent = 0;
  int cyc    = 0;

  sent_tx_frame_scheduler #(.NUM_REQ(NREQ), .DATA_NIBBLES(6)) dut (
    .clk_tx         (clk_tx),
    .reset_tx       (reset_tx),
    .enable_i       (enable_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .status_i       (status_i),
    .ssm_valid_i    (ssm_valid_i),
    .ssm_id_i       (ssm_id_i),
    .ssm_data_i     (ssm_data_i),
    .ssm_ready_o    (ssm_ready_o),
    .ssm_busy_o     (ssm_busy_o),
    .frame_valid_o  (frame_valid_o),
    .frame_status_o (frame_status_o),
    .frame_data_o   (frame_data_o),
    .frame_ready_i  (frame_ready_i),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk_tx = ~clk_tx;
  always @(posedge clk_tx) cyc <= cyc + 1;

  // Bit-serial long division, seed preloaded, message followed by four zero bits
  function automatic logic [3:0] crc_model(input logic [3:0] id, input logic [7:0] d);
    logic [3:0]  r;
    logic [15:0] msg;
    logic        msb;
    r   = 4'b0101;
    msg = {id, d, 4'h0};
    for (int b = 15; b >= 0; b--) begin
      msb = r[3];
      r   = {r[2:0], msg[b]};
      if (msb) r = r ^ 4'hD;
    end
    return r;
  endfunction

  function automatic logic [DWT-1:0] src_word(input int k);
    return {4'(k), 20'hC0DE0 + 20'(k)};
  endfunction

  // Scoreboard: compare every accepted frame against the oldest expectation
  always @(negedge clk_tx) begin
    frame_t exp_f;
    if (!reset_tx && frame_valid_o && frame_ready_i) begin
      hs_cnt = hs_cnt + 1;
      n_cmp  = n_cmp + 1;
      if (sb.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_frame: got status %h data %h, required no frame", frame_status_o, frame_data_o);
      end else begin
        exp_f = sb.pop_front();
        if ({frame_status_o, frame_data_o} !== exp_f) begin
          n_err = n_err + 1;
          $display("FAIL frame: got status %h data %h, required status %h data %h",
                   frame_status_o, frame_data_o, exp_f.status, exp_f.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_tx);
    #1;
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] exp_g, input string name);
    bit got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk_tx);
      if (req_ready_o != '0) begin
        got   = 1;
        n_cmp = n_cmp + 1;
        if (req_ready_o !== exp_g) begin
          n_err = n_err + 1;
          $display("FAIL %s: got grant %b, required %b", name, req_ready_o, exp_g);
        end
      end
      tick();
    end
    if (!got) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL %s: got no grant within 40 cycles, required %b", name, exp_g);
    end
  endtask

  task automatic wait_hs(input int target, input string name);
    for (int t = 0; t < 40 && hs_cnt < target; t++) tick();
    if (hs_cnt < target) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL %s: got %0d handshakes, required %0d", name, hs_cnt, target);
    end
  endtask

  task automatic send_frame(input int src, input logic [DWT-1:0] d, input logic [3:0] st, input string name);
    int hs0 = hs_cnt;
    sb.push_back({st, d});
    n_sent = n_sent + 1;
    req_data_i[src*DWT +: DWT] = d;
    req_valid_i[src] = 1'b1;
    wait_grant(NREQ'(1 << src), name);
    req_valid_i[src] = 1'b0;
    wait_hs(hs0 + 1, name);
  endtask

  task automatic check_cnt(input string name);
    n_cmp = n_cmp + 1;
    if (frame_cnt_o !== 16'(n_sent)) begin
      n_err = n_err + 1;
      $display("FAIL %s: got frame_cnt %0d, required %0d", name, frame_cnt_o, n_sent);
    end
  endtask

  task automatic test_reset();
    reset_tx = 1'b1; enable_i = 1'b1; req_valid_i = '1;
    for (int k = 0; k < NREQ; k++) req_data_i[k*DWT +: DWT] = src_word(k);
    status_i = 2'b11; ssm_valid_i = 1'b0; ssm_id_i = '0; ssm_data_i = '0; frame_ready_i = 1'b1;
    tick(); tick();
    n_cmp = n_cmp + 1;
    if ({frame_valid_o, frame_status_o, frame_data_o, frame_cnt_o, ssm_busy_o, ssm_ready_o} !== {1'b0, 4'h0, 24'h0, 16'h0, 1'b0, 1'b1}) begin
      n_err = n_err + 1;
      $display("FAIL reset_outputs: got valid %b st %h data %h cnt %h busy %b rdy %b, required 0/0/0/0/0/1",
               frame_valid_o, frame_status_o, frame_data_o, frame_cnt_o, ssm_busy_o, ssm_ready_o);
    end
    @(negedge clk_tx);
    n_cmp = n_cmp + 1;
    if (req_ready_o !== '0) begin
      n_err = n_err + 1;
      $display("FAIL reset_grant: got %b, required 0000", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    reset_tx = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int g = 0;
    int last = 0;
    int hs0 = hs_cnt;
    status_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      sb.push_back({4'b0010, src_word(order[i])});
      n_sent = n_sent + 1;
    end
    req_valid_i = '1;
    for (int t = 0; t < 60 && g < 5; t++) begin
      @(negedge clk_tx);
      if (req_ready_o != '0) begin
        n_cmp = n_cmp + 1;
        if (req_ready_o !== NREQ'(1 << order[g])) begin
          n_err = n_err + 1;
          $display("FAIL rr_order[%0d]: got %b, required %b", g, req_ready_o, NREQ'(1 << order[g]));
        end
        if (g > 0) begin
          n_cmp = n_cmp + 1;
          if (cyc - last != 2) begin
            n_err = n_err + 1;
            $display("FAIL rr_spacing[%0d]: got %0d cycles, required 2", g, cyc - last);
          end
        end
        last = cyc;
        g = g + 1;
      end
      tick();
    end
    req_valid_i = '0;
    if (g < 5) begin
      n_cmp = n_cmp + 1; n_err = n_err + 1;
      $display("FAIL rr_grants: got %0d grants, required 5", g);
    end
    wait_hs(hs0 + 5, "rr_frames");
    check_cnt("rr_cnt");
  endtask

  task automatic test_stall();
    int hs0 = hs_cnt;
    status_i = 2'b01;
    frame_ready_i = 1'b0;
    sb.push_back({4'b0001, 24'hABC123});
    n_sent = n_sent + 1;
    req_data_i[2*DWT +: DWT] = 24'hABC123;
    req_valid_i[2] = 1'b1;
    wait_grant(4'b0100, "stall_grant");
    req_valid_i[2] = 1'b0;
    status_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_tx);
      n_cmp = n_cmp + 1;
      if ({frame_valid_o, frame_status_o, frame_data_o, req_ready_o} !== {1'b1, 4'b0001, 24'hABC123, 4'b0000}) begin
        n_err = n_err + 1;
        $display("FAIL stall_hold[%0d]: got valid %b st %h data %h grant %b, required 1/1/abc123/0000",
                 i, frame_valid_o, frame_status_o, frame_data_o, req_ready_o);
      end
      tick();
    end
    frame_ready_i = 1'b1;
    wait_hs(hs0 + 1, "stall_hs");
    check_cnt("stall_cnt");
  endtask

  task automatic test_ssm_stream();
    logic [15:0] bits;
    status_i = 2'b11;
    ssm_id_i = 4'h1; ssm_data_i = 8'h5A; ssm_valid_i = 1'b1;
    @(negedge clk_tx);
    n_cmp = n_cmp + 1;
    if ({ssm_ready_o, ssm_busy_o} !== 2'b10) begin
      n_err = n_err + 1;
      $display("FAIL ssm_idle: got ready %b busy %b, required 1/0", ssm_ready_o, ssm_busy_o);
    end
    tick();
    ssm_valid_i = 1'b0;
    n_cmp = n_cmp + 1;
    if ({ssm_ready_o, ssm_busy_o} !== 2'b01) begin
      n_err = n_err + 1;
      $display("FAIL ssm_loaded: got ready %b busy %b, required 0/1", ssm_ready_o, ssm_busy_o);
    end
    bits = {4'h1, 8'h5A, crc_model(4'h1, 8'h5A)};
    for (int i = 0; i < 16; i++) begin
      send_frame(1, 24'h5A0000 + 24'(i), {(i == 0), bits[15-i], 2'b11}, "ssm_frame");
      n_cmp = n_cmp + 1;
      if ({ssm_busy_o, ssm_ready_o} !== {(i < 15), (i == 15)}) begin
        n_err = n_err + 1;
        $display("FAIL ssm_busy[%0d]: got busy %b ready %b, required %b/%b", i, ssm_busy_o, ssm_ready_o, (i < 15), (i == 15));
      end
    end
    check_cnt("ssm_cnt");
  endtask

  task automatic test_ssm_load_with_grant();
    logic [15:0] bits;
    int hs0 = hs_cnt;
    status_i = 2'b00;
    bits = {4'hA, 8'h3C, crc_model(4'hA, 8'h3C)};
    ssm_id_i = 4'hA; ssm_data_i = 8'h3C; ssm_valid_i = 1'b1;
    sb.push_back({1'b1, bits[15], 2'b00, 24'h444444});
    n_sent = n_sent + 1;
    req_data_i[3*DWT +: DWT] = 24'h444444;
    req_valid_i[3] = 1'b1;
    @(negedge clk_tx);
    n_cmp = n_cmp + 1;
    if ({req_ready_o, ssm_ready_o} !== {4'b1000, 1'b1}) begin
      n_err = n_err + 1;
      $display("FAIL same_cycle: got grant %b ssm_ready %b, required 1000/1", req_ready_o, ssm_ready_o);
    end
    tick();
    req_valid_i[3] = 1'b0;
    ssm_id_i = 4'h7; ssm_data_i = 8'hFF;
    n_cmp = n_cmp + 1;
    if ({ssm_ready_o, ssm_busy_o} !== 2'b01) begin
      n_err = n_err + 1;
      $display("FAIL busy_reload: got ready %b busy %b, required 0/1", ssm_ready_o, ssm_busy_o);
    end
    wait_hs(hs0 + 1, "same_cycle_hs");
    tick(); tick();
    ssm_valid_i = 1'b0;
    for (int i = 1; i < 16; i++) begin
      send_frame(3, 24'h300000 + 24'(i), {1'b0, bits[15-i], 2'b00}, "reload_frame");
    end
    n_cmp = n_cmp + 1;
    if ({ssm_busy_o, ssm_ready_o} !== 2'b01) begin
      n_err = n_err + 1;
      $display("FAIL reload_done: got busy %b ready %b, required 0/1", ssm_busy_o, ssm_ready_o);
    end
    check_cnt("reload_cnt");
  endtask

  task automatic test_enable_drain();
    int hs0 = hs_cnt;
    status_i = 2'b01;
    frame_ready_i = 1'b0;
    sb.push_back({4'b0001, 24'h555000});
    sb.push_back({4'b0001, 24'h111AAA});
    n_sent = n_sent + 2;
    req_data_i[0*DWT +: DWT] = 24'h555000;
    req_data_i[1*DWT +: DWT] = 24'h111AAA;
    req_data_i[2*DWT +: DWT] = 24'h222BBB;
    req_valid_i[0] = 1'b1;
    wait_grant(4'b0001, "drain_grant");
    enable_i = 1'b0;
    req_valid_i = 4'b0110;
    tick();
    frame_ready_i = 1'b1;
    wait_hs(hs0 + 1, "drain_hs");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_tx);
      n_cmp = n_cmp + 1;
      if ({req_ready_o, frame_valid_o} !== 5'b0000_0) begin
        n_err = n_err + 1;
        $display("FAIL disabled[%0d]: got grant %b valid %b, required 0000/0", i, req_ready_o, frame_valid_o);
      end
      tick();
    end
    enable_i = 1'b1;
    req_valid_i = 4'b0010;
    wait_grant(4'b0010, "reenable_grant");
    req_valid_i = '0;
    wait_hs(hs0 + 2, "reenable_hs");
    check_cnt("drain_cnt");
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits;
    status_i = 2'b00;
    bits = {4'h3, 8'hC7, crc_model(4'h3, 8'hC7)};
    ssm_id_i = 4'h3; ssm_data_i = 8'hC7; ssm_valid_i = 1'b1;
    tick();
    ssm_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_frame(2, 24'h600000 + 24'(i), {(i == 0), bits[15-i], 2'b00}, "pre_reset_frame");
    end
    frame_ready_i = 1'b0;
    req_valid_i[2] = 1'b1;
    wait_grant(4'b0100, "bit7_grant");
    req_valid_i[2] = 1'b0;
    n_cmp = n_cmp + 1;
    if ({frame_valid_o, frame_status_o, ssm_busy_o} !== {1'b1, 1'b0, bits[8], 2'b00, 1'b1}) begin
      n_err = n_err + 1;
      $display("FAIL bit7_offer: got valid %b st %h busy %b, required 1/%h/1",
               frame_valid_o, frame_status_o, ssm_busy_o, {1'b0, bits[8], 2'b00});
    end
    for (int k = 0; k < NREQ; k++) req_data_i[k*DWT +: DWT] = src_word(k);
    reset_tx = 1'b1;
    req_valid_i = '1;
    @(negedge clk_tx);
    n_cmp = n_cmp + 1;
    if (req_ready_o !== '0) begin
      n_err = n_err + 1;
      $display("FAIL mid_reset_grant: got %b, required 0000", req_ready_o);
    end
    tick();
    n_cmp = n_cmp + 1;
    if ({frame_valid_o, frame_status_o, frame_data_o, frame_cnt_o, ssm_busy_o, ssm_ready_o} !== {1'b0, 4'h0, 24'h0, 16'h0, 1'b0, 1'b1}) begin
      n_err = n_err + 1;
      $display("FAIL mid_reset_outputs: got valid %b st %h data %h cnt %h busy %b rdy %b, required 0/0/0/0/0/1",
               frame_valid_o, frame_status_o, frame_data_o, frame_cnt_o, ssm_busy_o, ssm_ready_o);
    end
    n_sent = 0;
    reset_tx = 1'b0;
    frame_ready_i = 1'b1;
    sb.push_back({4'b0000, src_word(0)});
    n_sent = 1;
    wait_grant(4'b0001, "post_reset_ptr");
    req_valid_i = '0;
    wait_hs(hs_cnt + 1, "post_reset_hs");
    check_cnt("post_reset_cnt");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_ssm_stream();
    test_ssm_load_with_grant();
    test_enable_drain();
    test_reset_mid_frame();
    tick();
    n_cmp = n_cmp + 1;
    if (sb.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL scoreboard_drain: got %0d pending frames, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
